// File: rtl/tl_pkg.sv
// Shared definitions for the timed two-road traffic-light controller.
//   - tl_state_e : 3-bit FSM state encoding (also driven out on the debug port)
//   - LAMP_*     : 2-bit lamp driver encoding
//   - DEF_*      : default timing constants, in ticks of the system time-base
//   - lamps_of() : Moore lamp decode shared by the controller
package tl_pkg;

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,  // all-red clearance after road A
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5,  // all-red clearance after road B
    FLASH  = 3'd6
  } tl_state_e;

  localparam logic [1:0] LAMP_GRN = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_RED = 2'b10;
  localparam logic [1:0] LAMP_OFF = 2'b11;

  localparam int unsigned DEF_CNT_W      = 8;
  localparam int unsigned DEF_MIN_GREEN  = 4;
  localparam int unsigned DEF_MAX_GREEN  = 16;
  localparam int unsigned DEF_YEL_T      = 3;
  localparam int unsigned DEF_RED_T      = 1;
  localparam int unsigned DEF_FLASH_HALF = 2;

  typedef struct packed {
    logic [1:0] la;
    logic [1:0] lb;
  } lamps_t;

  // Lamp pattern for a state. Everything not explicitly green/yellow is red,
  // so an unexpected encoding fails safe to all-red.
  function automatic lamps_t lamps_of(tl_state_e s, logic flash_ph);
    lamps_t l;
    l = '{la: LAMP_RED, lb: LAMP_RED};
    case (s)
      A_GRN: l.la = LAMP_GRN;
      A_YEL: l.la = LAMP_YEL;
      B_GRN: l.lb = LAMP_GRN;
      B_YEL: l.lb = LAMP_YEL;
      FLASH: begin
        l.la = flash_ph ? LAMP_OFF : LAMP_YEL;
        l.lb = l.la;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Per-phase tick counter for the traffic-light controller.
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   synchronous active-low reset (clears the counter)
//   tick      in   time-base enable; the counter advances only on tick
//   clr       in   clear request (state change or flash half-period toggle)
//   at_min    out  counter has reached the minimum-green threshold
//   at_max    out  counter is on the last tick of maximum green
//   at_yel    out  counter is on the last tick of yellow
//   at_red    out  counter is on the last tick of all-red clearance
//   at_flash  out  counter is on the last tick of a flash half-period
module tl_phase_timer
  import tl_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned MIN_GREEN  = DEF_MIN_GREEN,
  parameter int unsigned MAX_GREEN  = DEF_MAX_GREEN,
  parameter int unsigned YEL_T      = DEF_YEL_T,
  parameter int unsigned RED_T      = DEF_RED_T,
  parameter int unsigned FLASH_HALF = DEF_FLASH_HALF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic clr,
  output logic at_min,
  output logic at_max,
  output logic at_yel,
  output logic at_red,
  output logic at_flash
);

  // Thresholds are "last tick of the phase": the counter starts at 0 on entry.
  localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YEL_T - 1);
  localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(RED_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);  // saturates at all ones
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_min   = (cnt_q >= MIN_LAST);
  assign at_max   = (cnt_q == MAX_LAST);
  assign at_yel   = (cnt_q == YEL_LAST);
  assign at_red   = (cnt_q == RED_LAST);
  assign at_flash = (cnt_q == FLASH_LAST);

endmodule

// File: rtl/tl_cntr_timed.sv
// Timed two-road traffic-light controller: 6-phase Moore FSM with min/max
// green, yellow and all-red intervals, plus a night flash mode entered only
// from an all-red phase.
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   synchronous active-low reset (to RED_BA, all red)
//   tick       in   time-base enable; state, counter and flash phase hold when 0
//   Ta, Tb     in   traffic present on road A / road B
//   flash      in   night flash request (level)
//   La, Lb     out  lamp drivers: 00 green, 01 yellow, 10 red, 11 off
//   state      out  current FSM state (debug)
//   phase_end  out  one-cycle pulse in the cycle after each state change
module tl_cntr_timed
  import tl_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned MIN_GREEN  = DEF_MIN_GREEN,
  parameter int unsigned MAX_GREEN  = DEF_MAX_GREEN,
  parameter int unsigned YEL_T      = DEF_YEL_T,
  parameter int unsigned RED_T      = DEF_RED_T,
  parameter int unsigned FLASH_HALF = DEF_FLASH_HALF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       flash,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [2:0] state,
  output logic       phase_end
);

  // Reject timing sets the counter cannot represent or that make no sense.
  if ((MIN_GREEN < 1) || (MAX_GREEN < MIN_GREEN) || (YEL_T < 1) ||
      (RED_T < 1) || (FLASH_HALF < 1) ||
      ((CNT_W < 32) && (MAX_GREEN > (32'd1 << CNT_W)))) begin : g_bad_params
    $error("tl_cntr_timed: illegal timing parameters");
  end

  tl_state_e state_q, state_d;
  logic      flash_ph_q, flash_ph_d;
  logic      phase_end_q;
  lamps_t    lamps_q;

  logic at_min, at_max, at_yel, at_red, at_flash;
  logic state_chg, flash_tog;

  tl_phase_timer #(
    .CNT_W     (CNT_W),
    .MIN_GREEN (MIN_GREEN),
    .MAX_GREEN (MAX_GREEN),
    .YEL_T     (YEL_T),
    .RED_T     (RED_T),
    .FLASH_HALF(FLASH_HALF)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .clr     (state_chg | flash_tog),
    .at_min  (at_min),
    .at_max  (at_max),
    .at_yel  (at_yel),
    .at_red  (at_red),
    .at_flash(at_flash)
  );

  // Next-state logic; nothing moves without a tick.
  always_comb begin
    state_d   = state_q;
    flash_tog = 1'b0;
    if (tick) begin
      case (state_q)
        A_GRN:  if ((at_min && !Ta) || at_max) state_d = A_YEL;
        A_YEL:  if (at_yel) state_d = RED_AB;
        RED_AB: if (at_red) state_d = flash ? FLASH : B_GRN;
        B_GRN:  if ((at_min && !Tb) || at_max) state_d = B_YEL;
        B_YEL:  if (at_yel) state_d = RED_BA;
        RED_BA: if (at_red) state_d = flash ? FLASH : A_GRN;
        FLASH: begin
          // Leaving flash goes through RED_BA so road A is served next.
          if (!flash)        state_d   = RED_BA;
          else if (at_flash) flash_tog = 1'b1;
        end
        default: state_d = RED_BA;  // unused encoding recovers to all-red
      endcase
    end
  end

  assign state_chg  = (state_d != state_q);
  assign flash_ph_d = state_chg ? 1'b0 : (flash_ph_q ^ flash_tog);

  // Lamps are registered from the next state, so they always equal the
  // decode of the registered state and flash phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= RED_BA;
      flash_ph_q  <= 1'b0;
      phase_end_q <= 1'b0;
      lamps_q     <= '{la: LAMP_RED, lb: LAMP_RED};
    end else begin
      state_q     <= state_d;
      flash_ph_q  <= flash_ph_d;
      phase_end_q <= state_chg;
      lamps_q     <= lamps_of(state_d, flash_ph_d);
    end
  end

  assign La        = lamps_q.la;
  assign Lb        = lamps_q.lb;
  assign state     = state_q;
  assign phase_end = phase_end_q;

endmodule

// File: tb/tb_tl_cntr_timed.sv
// Self-checking bench for tl_cntr_timed with MIN=3, MAX=8, YEL=2, RED=1,
// FLASH_HALF=2. A tick-counting reference model is compared against the DUT
// every cycle; directed scenarios add hand-computed literal expectations.
module tb_tl_cntr_timed;

  localparam int MIN_G = 3;
  localparam int MAX_G = 8;
  localparam int YEL   = 2;
  localparam int RED   = 1;
  localparam int FHALF = 2;

  localparam int S_AG = 0, S_AY = 1, S_RAB = 2, S_BG = 3, S_BY = 4, S_RBA = 5, S_FL = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b1;
  logic       Ta = 1'b0, Tb = 1'b0, flash = 1'b0;
  logic [1:0] La, Lb;
  logic [2:0] state;
  logic       phase_end;

  int n_tests = 0;
  int n_fail  = 0;

  tl_cntr_timed #(
    .CNT_W(8), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G),
    .YEL_T(YEL), .RED_T(RED), .FLASH_HALF(FHALF)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .Ta       (Ta),
    .Tb       (Tb),
    .flash    (flash),
    .La       (La),
    .Lb       (Lb),
    .state    (state),
    .phase_end(phase_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lamp pattern {La,Lb} a phase must show.
  function automatic logic [3:0] exp_lamps(input int st, input bit ph);
    case (st)
      S_AG:    return 4'b00_10;
      S_AY:    return 4'b01_10;
      S_RAB:   return 4'b10_10;
      S_BG:    return 4'b10_00;
      S_BY:    return 4'b10_01;
      S_RBA:   return 4'b10_10;
      S_FL:    return ph ? 4'b11_11 : 4'b01_01;
      default: return 4'b0000;
    endcase
  endfunction

  // Reference model: phase plus number of ticks already spent in it.
  int m_st = S_RBA;
  int m_ticks = 0;
  bit m_ph = 1'b0;
  bit m_pe = 1'b0;
  bit s_tick = 1'b0;
  bit s_rst = 1'b0;

  always @(posedge clk) begin : model
    int n;
    int nxt;
    bit tog;
    s_tick = tick;
    s_rst  = reset_n;
    if (!reset_n) begin
      m_st = S_RBA; m_ticks = 0; m_ph = 1'b0; m_pe = 1'b0;
    end else if (!tick) begin
      m_pe = 1'b0;
    end else begin
      n   = m_ticks + 1;  // including the tick happening now
      nxt = m_st;
      tog = 1'b0;
      case (m_st)
        S_AG:  if ((n >= MIN_G && !Ta) || n >= MAX_G) nxt = S_AY;
        S_AY:  if (n == YEL) nxt = S_RAB;
        S_RAB: if (n == RED) nxt = flash ? S_FL : S_BG;
        S_BG:  if ((n >= MIN_G && !Tb) || n >= MAX_G) nxt = S_BY;
        S_BY:  if (n == YEL) nxt = S_RBA;
        S_RBA: if (n == RED) nxt = flash ? S_FL : S_AG;
        S_FL:  if (!flash) nxt = S_RBA; else if (n == FHALF) tog = 1'b1;
        default: ;
      endcase
      m_pe = (nxt != m_st);
      if (nxt != m_st) begin
        m_st = nxt; m_ticks = 0; m_ph = 1'b0;
      end else if (tog) begin
        m_ph = ~m_ph; m_ticks = 0;
      end else begin
        m_ticks = n;
      end
    end
  end

  // Per-cycle compare, safety invariant and green-length monitor.
  int prev_st = S_RBA;
  int g_ticks = 0;

  always @(negedge clk) begin : compare
    logic [3:0] el;
    el = exp_lamps(m_st, m_ph);
    check("state", 32'(state), 32'(m_st));
    check("La", 32'(La), 32'(el[3:2]));
    check("Lb", 32'(Lb), 32'(el[1:0]));
    check("phase_end", 32'(phase_end), 32'(m_pe));
    if (state != 3'(S_FL)) check("safety", 32'(!La[1] && !Lb[1]), 32'd0);
    if (!s_rst) begin
      g_ticks = 0;
    end else if (prev_st == S_AG || prev_st == S_BG) begin
      if (s_tick) g_ticks++;
      if (int'(state) != prev_st) begin
        check("green_ge_min", 32'(g_ticks >= MIN_G), 32'd1);
        check("green_le_max", 32'(g_ticks <= MAX_G), 32'd1);
        g_ticks = 0;
      end
    end
    prev_st = int'(state);
  end

  // Inputs change just after a falling edge; the next rising edge samples them.
  task automatic step(input bit tk, input bit ta, input bit tb, input bit fl);
    tick = tk; Ta = ta; Tb = tb; flash = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  // Cycles spent in A_GRN with Ta held 1 until drop_at green cycles seen.
  task automatic green_len(input int drop_at, output int len);
    int guard;
    guard = 0;
    len   = 0;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);  // RED_BA -> A_GRN
    while (state == 3'(S_AG) && guard < 50) begin
      len++;
      guard++;
      step(1'b1, len < drop_at, 1'b0, 1'b0);
    end
  endtask

  // Hand-computed sequences.
  int seq_st[10]  = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 4};
  bit seq_pe[10]  = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1};
  int fl_st[13]   = '{0, 0, 1, 1, 2, 6, 6, 6, 6, 6, 6, 6, 6};
  int fl_la[13]   = '{0, 0, 1, 1, 2, 1, 1, 3, 3, 1, 1, 3, 3};
  int fl_lb[13]   = '{2, 2, 2, 2, 2, 1, 1, 3, 3, 1, 1, 3, 3};

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int len, cg, cy, cbg;
    bit fl_r, tk;

    // Reset state and the basic cycle with no traffic.
    do_reset();
    check("rst_state", 32'(state), S_RBA);
    check("rst_La", 32'(La), 32'd2);
    check("rst_Lb", 32'(Lb), 32'd2);
    check("rst_pe", 32'(phase_end), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("seq_state", 32'(state), 32'(seq_st[i]));
      check("seq_pe", 32'(phase_end), 32'(seq_pe[i]));
    end

    // Reset in the middle of B_YEL: no change until an edge, then all-red.
    check("pre_rst_state", 32'(state), S_BY);
    reset_n = 1'b0;
    #2;
    check("rst_no_edge_state", 32'(state), S_BY);
    check("rst_no_edge_Lb", 32'(Lb), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_state", 32'(state), S_RBA);
    check("mid_rst_La", 32'(La), 32'd2);
    check("mid_rst_Lb", 32'(Lb), 32'd2);
    check("mid_rst_pe", 32'(phase_end), 32'd0);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);  // cnt restarted at 0: one clearance tick
    check("post_rst_state", 32'(state), S_AG);

    // Maximum green with Ta held, and Ta released on the fifth green tick.
    green_len(99, len);
    check("max_green_len", 32'(len), 32'd8);
    check("max_green_next", 32'(state), S_AY);
    green_len(5, len);
    check("drop5_green_len", 32'(len), 32'd5);
    check("drop5_next", 32'(state), S_AY);

    // Tick every 4th cycle; Ta/Tb noise only between ticks.
    do_reset();
    cg = 0; cy = 0; cbg = 0;
    for (int c = 0; c < 40; c++) begin
      tk = (c % 4 == 0);
      step(tk, tk ? 1'b0 : 1'($urandom_range(1)), tk ? 1'b0 : 1'($urandom_range(1)), 1'b0);
      if (state == 3'(S_AG)) cg++;
      if (state == 3'(S_AY)) cy++;
      if (state == 3'(S_BG)) cbg++;
    end
    check("slow_a_green", 32'(cg), 32'd12);
    check("slow_a_yellow", 32'(cy), 32'd8);
    check("slow_b_green", 32'(cbg), 32'd12);

    // Flash requested during A_GRN: normal A cycle, then flash, then exit.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("fl_state", 32'(state), 32'(fl_st[i]));
      check("fl_La", 32'(La), 32'(fl_la[i]));
      check("fl_Lb", 32'(Lb), 32'(fl_lb[i]));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("fl_exit_state", 32'(state), S_RBA);
    check("fl_exit_La", 32'(La), 32'd2);
    check("fl_exit_pe", 32'(phase_end), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("fl_then_a_green", 32'(state), S_AG);
    check("fl_then_La", 32'(La), 32'd0);

    // Long random run; the compare process does the checking.
    do_reset();
    fl_r = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(99) == 0) fl_r = ~fl_r;
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), fl_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
